// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : simon_pkg
//  Description : Shared Simon game definitions. Provides the colour codes,
//                the per-colour tone half-periods and small lookup helpers.
//                Used by the cue player, the button debouncer and the game
//                sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package simon_pkg;

    // Colour codes; the LED bit index equals the colour code
    localparam logic [1:0] c_GREEN  = 2'd0;
    localparam logic [1:0] c_RED    = 2'd1;
    localparam logic [1:0] c_YELLOW = 2'd2;
    localparam logic [1:0] c_BLUE   = 2'd3;

    // Tone half-periods in clocks (about 415/310/252/209 Hz at 50 kHz)
    localparam logic [6:0] c_HALF_GREEN  = 7'd60;
    localparam logic [6:0] c_HALF_RED    = 7'd81;
    localparam logic [6:0] c_HALF_YELLOW = 7'd99;
    localparam logic [6:0] c_HALF_BLUE   = 7'd120;

    // One-hot LED pattern for a colour code
    function automatic logic [3:0] color_onehot(input logic [1:0] color);
        color_onehot = 4'b0001 << color;
    endfunction

    // Tone half-period for a colour code
    function automatic logic [6:0] half_period_of(input logic [1:0] color);
        case (color)
            c_GREEN:  half_period_of = c_HALF_GREEN;
            c_RED:    half_period_of = c_HALF_RED;
            c_YELLOW: half_period_of = c_HALF_YELLOW;
            c_BLUE:   half_period_of = c_HALF_BLUE;
            default:  half_period_of = c_HALF_GREEN;
        endcase
    endfunction

endpackage : simon_pkg
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tone_gen
//  Description : Free-running square-wave divider for the piezo. The output
//                toggles every half_period enabled cycles and is held low
//                (with the divider cleared) whenever enable is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] half_period,
    output logic       tone
);

    logic [6:0] r_div;
    logic       r_tone;

    // Divider and tone flop. The owner raises enable on the accept edge, one
    // cycle ahead of the first ON cycle, so counting restarts at 1 after a
    // toggle to land the first rising edge exactly half_period cycles into ON.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_div  <= 7'd0;
            r_tone <= 1'b0;
        end else if (r_div == half_period) begin
            r_div  <= 7'd1;
            r_tone <= ~r_tone;
        end else begin
            r_div  <= r_div + 7'd1;
        end
    end

    assign tone = r_tone;

endmodule : tone_gen
`default_nettype wire

// File: rtl/simon_cue_player.sv
`default_nettype none
// ============================================================================
//  Module      : simon_cue_player
//  Description : Output-side cue driver for the Simon game. Accepts one colour
//                request over valid/ready, lights the matching LED with its
//                tone for ON_CYCLES clocks, then holds a dark gap of
//                GAP_CYCLES clocks and pulses done. A stop input aborts the
//                cue at any point without a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module simon_cue_player
    import simon_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int ON_CYCLES  = 25000,
    parameter int GAP_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_color,
    output logic       req_ready,
    input  logic       stop,
    output logic [3:0] led,
    output logic       tone,
    output logic       busy,
    output logic       done
);

    // State encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ON   = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    // Terminal counts of the duration counter
    localparam logic [CNT_W-1:0] c_ON_TC  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_TC = CNT_W'(GAP_CYCLES - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_color;
    logic [3:0]       r_led;
    logic             r_busy;
    logic             r_done;
    logic             r_req_ready;

    logic             w_accept;
    logic             w_tone_en;
    logic [6:0]       w_half;

    // A request is taken only in IDLE, and stop always wins over it
    assign w_accept = (r_state == c_ST_IDLE) && req_valid && !stop;

    // Tone runs while the next cycle is an ON cycle, so it is low on the
    // first GAP cycle and on the cycle after any stop
    assign w_tone_en = w_accept ||
                       ((r_state == c_ST_ON) && !stop && (r_cnt != c_ON_TC));

    assign w_half = half_period_of(r_color);

    // Cue sequencing: state, duration counter, latched colour and all
    // registered outputs are updated together on each edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_color     <= c_GREEN;
            r_led       <= 4'b0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= c_ST_ON;
                        r_cnt       <= '0;
                        r_color     <= req_color;
                        r_led       <= color_onehot(req_color);
                        r_busy      <= 1'b1;
                        r_req_ready <= 1'b0;
                    end
                end
                c_ST_ON: begin
                    if (stop) begin
                        r_state     <= c_ST_IDLE;
                        r_cnt       <= '0;
                        r_led       <= 4'b0000;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end else if (r_cnt == c_ON_TC) begin
                        r_state <= c_ST_GAP;
                        r_cnt   <= '0;
                        r_led   <= 4'b0000;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_ST_GAP: begin
                    if (stop) begin
                        r_state     <= c_ST_IDLE;
                        r_cnt       <= '0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end else if (r_cnt == c_GAP_TC) begin
                        r_state     <= c_ST_IDLE;
                        r_cnt       <= '0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_done      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_cnt       <= '0;
                    r_led       <= 4'b0000;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    tone_gen u_tone_gen (
        .clk         (clk),
        .reset       (reset),
        .enable      (w_tone_en),
        .half_period (w_half),
        .tone        (tone)
    );

    assign led       = r_led;
    assign busy      = r_busy;
    assign done      = r_done;
    assign req_ready = r_req_ready;

endmodule : simon_cue_player
`default_nettype wire
